ad_coe_ctrl: RTL and testbench

Slot sequencer and double-buffered coefficient loader for the 16-tap time-multiplexed complex MAC beamformer. It generates the 16-slot frame count at 61.44 MHz, which is 16 slots per 3.84 Msps sample. From that count it derives the shift-register write strobe and the accumulator bypass strobe. It also accepts new weight vectors from the weight-computation engine over a valid/ready stream, writes them into the inactive half of a 32-entry coefficient RAM, and swaps banks only on a frame boundary, so a frame never mixes old and new weights.

---
 rtl/ad_coe_ctrl_if.sv | 16 +
 rtl/ad_coe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ad_coe_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ad_coe_ctrl_if.sv
// Weight-update stream between the weight-computation engine (master) and
// the coefficient loader (slave): valid/ready handshake with end-of-vector marker.
interface ad_coe_ctrl_if #(
  parameter int DW = 16
) ();
  logic          upd_valid;
  logic          upd_ready;
  logic          upd_last;
  logic [DW-1:0] upd_r;
  logic [DW-1:0] upd_i;

  modport master (output upd_valid, output upd_last, output upd_r, output upd_i,
                  input  upd_ready);
  modport slave  (input  upd_valid, input  upd_last, input  upd_r, input  upd_i,
                  output upd_ready);
endinterface

// File: rtl/ad_coe_ctrl.sv
// Slot sequencer and double-buffered coefficient loader for the 16-tap complex MAC.
// Optional vector-length check compiled in with macro AD_COE_CHK_EN.
module ad_coe_ctrl #(
  parameter int NTAP     = 16,
  parameter int AW       = 4,
  parameter int DW       = 16,
  parameter int BYP_SLOT = 4
) (
  input  logic          clk_61p44MHz,
  input  logic          reset,
  ad_coe_ctrl_if.slave  upd,
  input  logic          err_clr,
  output logic [AW-1:0] slot,
  output logic          srl_we,
  output logic          bypass,
  output logic [AW:0]   rd_addr,
  output logic [AW:0]   wr_addr,
  output logic          we_coe,
  output logic [DW-1:0] coe_r,
  output logic [DW-1:0] coe_i,
  output logic          act_bank,
  output logic          swap_done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] slot_q, slot_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          act_bank_q, act_bank_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic          swap_q, swap_d;
  logic          err_q, err_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0] coe_r_q, coe_r_d;
  logic [DW-1:0] coe_i_q, coe_i_d;

  logic          acc_s;
  logic          last_idx_s;
  logic          frame_end_s;
  logic          bad_s;

  assign acc_s       = upd.upd_valid && ready_q;
  assign last_idx_s  = (idx_q == AW'(NTAP - 1));
  assign frame_end_s = (slot_q == AW'(NTAP - 1));

`ifdef AD_COE_CHK_EN
  assign bad_s = (upd.upd_last && !last_idx_s) || (!upd.upd_last && last_idx_s);
`else
  logic chk_unused_s;
  assign chk_unused_s = ^{upd.upd_last, err_clr};
  assign bad_s        = 1'b0;
`endif

  // Next-state logic for slot counter, load FSM, bank select and write port.
  always_comb begin
    slot_d     = frame_end_s ? '0 : slot_q + AW'(1);
    state_d    = state_q;
    idx_d      = idx_q;
    act_bank_d = act_bank_q;
    ready_d    = ready_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    coe_r_d    = coe_r_q;
    coe_i_d    = coe_i_q;
    swap_d     = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (acc_s && bad_s) begin
          state_d = S_IDLE;
          idx_d   = '0;
          ready_d = 1'b1;
        end else if (acc_s) begin
          // The bank under write is always the one the datapath is not reading.
          we_d      = 1'b1;
          wr_addr_d = {~act_bank_q, idx_q};
          coe_r_d   = upd.upd_r;
          coe_i_d   = upd.upd_i;
          if (last_idx_s) begin
            state_d = S_PEND;
            idx_d   = '0;
            ready_d = 1'b0;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + AW'(1);
            ready_d = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_PEND: begin
        if (frame_end_s) begin
          act_bank_d = ~act_bank_q;
          swap_d     = 1'b1;
          state_d    = S_IDLE;
          ready_d    = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        ready_d = 1'b1;
      end
    endcase
`ifdef AD_COE_CHK_EN
    err_d = (acc_s && bad_s) || (err_q && !err_clr);
`else
    err_d = 1'b0;
`endif
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk_61p44MHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      idx_q      <= '0;
      act_bank_q <= 1'b0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      swap_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      coe_r_q    <= '0;
      coe_i_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      act_bank_q <= act_bank_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      swap_q     <= swap_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      coe_r_q    <= coe_r_d;
      coe_i_q    <= coe_i_d;
    end
  end

  assign upd.upd_ready = ready_q;
  assign slot          = slot_q;
  assign srl_we        = (slot_q == '0);
  assign bypass        = (slot_q == AW'(BYP_SLOT));
  assign rd_addr       = {act_bank_q, slot_q};
  assign wr_addr       = wr_addr_q;
  assign we_coe        = we_q;
  assign coe_r         = coe_r_q;
  assign coe_i         = coe_i_q;
  assign act_bank      = act_bank_q;
  assign swap_done     = swap_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ad_coe_ctrl.sv
// Self-checking bench for ad_coe_ctrl: frame-level reference model of slots,
// vector loading, bank swapping and RAM contents, driven by directed/random steps.
`timescale 1ns/1ps
module tb_ad_coe_ctrl;
  localparam int NTAP = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int BYP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clr = 1'b0;
  always #5 clk = ~clk;

  ad_coe_ctrl_if #(.DW(DW)) upd ();

  logic [AW-1:0] slot;
  logic          srl_we, bypass, we_coe, act_bank, swap_done, err;
  logic [AW:0]   rd_addr, wr_addr;
  logic [DW-1:0] coe_r, coe_i;

  ad_coe_ctrl #(.NTAP(NTAP), .AW(AW), .DW(DW), .BYP_SLOT(BYP)) dut (
    .clk_61p44MHz(clk), .reset(reset), .upd(upd), .err_clr(err_clr),
    .slot(slot), .srl_we(srl_we), .bypass(bypass), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .we_coe(we_coe), .coe_r(coe_r), .coe_i(coe_i),
    .act_bank(act_bank), .swap_done(swap_done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int            slot_m = 0;
  int            cnt = 0;
  int            swaps = 0;
  int            dut_swaps = 0;
  bit            bank_m = 1'b0, pending = 1'b0, rdy_exp = 1'b0;
  bit            wr_exp = 1'b0, swp_exp = 1'b0, err_m = 1'b0;
  bit            have [2];
  logic [AW:0]   wa_exp;
  logic [DW-1:0] wr_r_exp, wr_i_exp;
  logic [DW-1:0] vec_r [NTAP], vec_i [NTAP];
  logic [DW-1:0] exp_r [2][NTAP], exp_i [2][NTAP];
  logic [DW-1:0] ram_r [2*NTAP], ram_i [2*NTAP];
  logic [DW-1:0] tv_r [NTAP], tv_i [NTAP];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic tick();
    bit acc, bad;
    acc = upd.upd_valid && rdy_exp;
    @(posedge clk);
    if (reset) begin
      slot_m = 0; bank_m = 1'b0; pending = 1'b0; cnt = 0; rdy_exp = 1'b0;
      wr_exp = 1'b0; swp_exp = 1'b0; err_m = 1'b0; have[0] = 1'b0; have[1] = 1'b0;
    end else begin
      wr_exp = 1'b0; swp_exp = 1'b0; bad = 1'b0;
      if (pending && slot_m == NTAP-1) begin
        bank_m = ~bank_m; pending = 1'b0; swp_exp = 1'b1; swaps++;
        for (int i = 0; i < NTAP; i++) begin
          exp_r[bank_m][i] = vec_r[i]; exp_i[bank_m][i] = vec_i[i];
        end
        have[bank_m] = 1'b1;
      end
`ifdef AD_COE_CHK_EN
      bad   = acc && (upd.upd_last != (cnt == NTAP-1));
      err_m = bad || (err_m && !err_clr);
`endif
      if (bad) cnt = 0;
      else if (acc) begin
        wr_exp = 1'b1; wa_exp = {~bank_m, AW'(cnt)};
        wr_r_exp = upd.upd_r; wr_i_exp = upd.upd_i;
        vec_r[cnt] = upd.upd_r; vec_i[cnt] = upd.upd_i;
        cnt++;
        if (cnt == NTAP) begin pending = 1'b1; cnt = 0; end
      end
      rdy_exp = ~pending;
      slot_m  = (slot_m + 1) % NTAP;
    end
    #1;
    chk("slot", slot, slot_m);
    chk("srl_we", srl_we, slot_m == 0);
    chk("bypass", bypass, slot_m == BYP);
    chk("rd_addr", rd_addr, {bank_m, AW'(slot_m)});
    chk("upd_ready", upd.upd_ready, rdy_exp);
    chk("we_coe", we_coe, wr_exp);
    if (wr_exp) begin
      chk("wr_addr", wr_addr, wa_exp);
      chk("coe_r", coe_r, wr_r_exp);
      chk("coe_i", coe_i, wr_i_exp);
    end
    chk("swap_done", swap_done, swp_exp);
    chk("act_bank", act_bank, bank_m);
    chk("err", err, err_m);
    if (swap_done === 1'b1) dut_swaps++;
    if (we_coe === 1'b1) begin ram_r[wr_addr] = coe_r; ram_i[wr_addr] = coe_i; end
    if (have[bank_m]) begin
      chk("ram_r", ram_r[rd_addr], exp_r[bank_m][slot_m]);
      chk("ram_i", ram_i[rd_addr], exp_i[bank_m][slot_m]);
    end
  endtask

  task automatic idle(input int n);
    upd.upd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [DW-1:0] r, input logic [DW-1:0] i,
                           input logic last, input int gap_pct);
    int b;
    while ($urandom_range(99) < gap_pct) begin upd.upd_valid = 1'b0; tick(); end
    upd.upd_valid = 1'b1; upd.upd_r = r; upd.upd_i = i; upd.upd_last = last;
    b = 0;
    while (!rdy_exp && b < 4*NTAP) begin tick(); b++; end
    chk("ready_wait", b < 4*NTAP, 1'b1);
    tick();
    upd.upd_valid = 1'b0;
  endtask

  task automatic fill_tv();
    for (int k = 0; k < NTAP; k++) begin tv_r[k] = DW'($urandom); tv_i[k] = DW'($urandom); end
  endtask

  task automatic send_tv(input int gap_pct, input int last_at, input bit boundary);
    int b;
    for (int k = 0; k < NTAP; k++) begin
      if (boundary && k == NTAP-1) begin
        upd.upd_valid = 1'b0; b = 0;
        while (slot_m != NTAP-2 && b < 2*NTAP) begin tick(); b++; end
      end
      send_word(tv_r[k], tv_i[k], k == last_at, (boundary && k == NTAP-1) ? 0 : gap_pct);
    end
  endtask

  task automatic wait_swap();
    int d0, b;
    d0 = dut_swaps; b = 0;
    upd.upd_valid = 1'b0;
    while (dut_swaps == d0 && b < 2*NTAP+4) begin tick(); b++; end
    chk("swap_wait", dut_swaps - d0, 1);
  endtask

  initial begin
    bit bank_before;
    int d0;
    upd.upd_valid = 1'b0; upd.upd_last = 1'b0; upd.upd_r = '0; upd.upd_i = '0;
    repeat (3) tick();
    chk("rst_ready", upd.upd_ready, 1'b0);
    reset = 1'b0;

    // free-running slots
    idle(40);

    // contiguous load k, -k
    for (int k = 0; k < NTAP; k++) begin tv_r[k] = DW'(k); tv_i[k] = DW'(-k); end
    send_tv(0, NTAP-1, 1'b0);
    wait_swap();
    chk("load_bank", act_bank, 1'b1);
    idle(NTAP + 2);

    // random vectors with gaps
    for (int n = 0; n < 3; n++) begin
      fill_tv(); send_tv(30, NTAP-1, 1'b0); wait_swap(); idle($urandom_range(1, 20));
    end

    // boundary swap, same vector without then with gaps
    fill_tv();
    for (int g = 0; g < 2; g++) begin
      bank_before = bank_m;
      send_tv(g * 40, NTAP-1, 1'b1);
      chk("bnd_slot", slot, NTAP-1);
      chk("bnd_we", we_coe, 1'b1);
      upd.upd_valid = 1'b0;
      tick();
      chk("bnd_rd", rd_addr, {~bank_before, AW'(0)});
      chk("bnd_swap", swap_done, 1'b1);
      idle(NTAP + 3);
    end

    // reset mid-load
    fill_tv();
    for (int k = 0; k < 8; k++) send_word(tv_r[k], tv_i[k], 1'b0, 20);
    reset = 1'b1;
    tick();
    chk("rst_we", we_coe, 1'b0);
    chk("rst_bank", act_bank, 1'b0);
    chk("rst_slot", slot, 0);
    chk("rst_swap", swap_done, 1'b0);
    reset = 1'b0;
    d0 = dut_swaps;
    idle(NTAP + 4);
    chk("rst_noswap", dut_swaps - d0, 0);
    fill_tv(); send_tv(20, NTAP-1, 1'b0); wait_swap();
    chk("rst_newbank", act_bank, 1'b1);
    idle(NTAP + 2);

`ifdef AD_COE_CHK_EN
    fill_tv();
    for (int k = 0; k < 10; k++) send_word(tv_r[k], tv_i[k], k == 9, 0);
    chk("bad_err", err, 1'b1);
    chk("bad_ready", upd.upd_ready, 1'b1);
    d0 = dut_swaps;
    idle(2*NTAP);
    chk("bad_noswap", dut_swaps - d0, 0);
    fill_tv(); send_tv(10, NTAP-1, 1'b0); wait_swap();
    chk("bad_errhold", err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("bad_errclr", err, 1'b0);
    idle(NTAP + 2);
`else
    fill_tv(); send_tv(10, -1, 1'b0); wait_swap();
    chk("nolast_err", err, 1'b0);
    idle(NTAP + 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
